// File: rtl/axi4lite_csr_pkg.sv
// AXI4-Lite CSR slave shared types.
// Response codes and FSM state encodings.
package axi4lite_csr_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rstate_e;

endpackage

// File: rtl/axi4lite_csr_slave.sv
// AXI4-Lite slave exposing RW control registers
// followed by read-only status words.
module axi4lite_csr_slave
  import axi4lite_csr_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 16,
  parameter int          NUM_RW       = 8,
  parameter int          NUM_RO       = 8,
  parameter logic [31:0] RW_RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [31:0]             wdata,
  input  logic [3:0]              wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [31:0]             rdata,
  output logic [1:0]              rresp,
  output logic [NUM_RW*32-1:0]    ctrl_regs,
  output logic [NUM_RW-1:0]       ctrl_wr_pulse,
  input  logic [NUM_RO*32-1:0]    status_in
);

  localparam int IW = ADDR_WIDTH - 2;
  typedef logic [IW-1:0] idx_t;

  function automatic resp_e decode(idx_t idx);
    if (idx < idx_t'(NUM_RW))
      return RESP_OKAY;
    else if (idx < idx_t'(NUM_RW + NUM_RO))
      return RESP_SLVERR;
    else
      return RESP_DECERR;
  endfunction

  wstate_e         w_state, w_next;
  rstate_e         r_state, r_next;
  logic            pend, pend_next;
  logic            commit;
  idx_t            w_idx;
  idx_t            ar_idx;
  logic [31:0]     w_data;
  logic [3:0]      w_strb;
  logic [31:0]     regs [NUM_RW];
  logic [NUM_RW-1:0] pulse;
  resp_e           b_resp;
  resp_e           r_resp;
  resp_e           rd_resp;
  logic [31:0]     r_data;
  logic [31:0]     rd_word;
  logic            unused;

  assign unused = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};
  assign ar_idx = araddr[ADDR_WIDTH-1:2];

  // pend marks "AW and W both held"; the commit happens one cycle later
  always_comb begin
    w_next    = w_state;
    pend_next = 1'b0;
    commit    = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    if (pend) begin
      commit = 1'b1;
      w_next = W_RESP;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          awready = 1'b1;
          wready  = 1'b1;
          if (awvalid && wvalid)
            pend_next = 1'b1;
          else if (awvalid)
            w_next = W_HAVE_AW;
          else if (wvalid)
            w_next = W_HAVE_W;
        end
        W_HAVE_AW: begin
          wready = 1'b1;
          if (wvalid) pend_next = 1'b1;
        end
        W_HAVE_W: begin
          awready = 1'b1;
          if (awvalid) pend_next = 1'b1;
        end
        W_RESP: begin
          bvalid = 1'b1;
          if (bready) w_next = W_IDLE;
        end
        default: w_next = W_IDLE;
      endcase
    end
    if (rst) begin
      commit  = 1'b0;
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
    end
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = R_RESP;
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
    if (rst) begin
      arready = 1'b0;
      rvalid  = 1'b0;
    end
  end

  always_comb begin
    rd_word = '0;
    rd_resp = decode(ar_idx);
    for (int i = 0; i < NUM_RW; i++)
      if (ar_idx == idx_t'(i)) rd_word = regs[i];
    for (int i = 0; i < NUM_RO; i++)
      if (ar_idx == idx_t'(NUM_RW + i))
        rd_word = status_in[32*i +: 32];
    if (rd_resp == RESP_SLVERR) rd_resp = RESP_OKAY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      pend    <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      pend    <= pend_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_idx  <= '0;
      w_data <= '0;
      w_strb <= '0;
      b_resp <= RESP_OKAY;
      pulse  <= '0;
      r_data <= '0;
      r_resp <= RESP_OKAY;
      for (int i = 0; i < NUM_RW; i++)
        regs[i] <= RW_RESET_VAL;
    end else begin
      pulse <= '0;
      if (awvalid && awready)
        w_idx <= awaddr[ADDR_WIDTH-1:2];
      if (wvalid && wready) begin
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (commit) begin
        b_resp <= decode(w_idx);
        for (int i = 0; i < NUM_RW; i++) begin
          if (w_idx == idx_t'(i)) begin
            pulse[i] <= 1'b1;
            for (int b = 0; b < 4; b++)
              if (w_strb[b])
                regs[i][8*b +: 8] <= w_data[8*b +: 8];
          end
        end
      end
      // regs still hold pre-commit values here
      if (arvalid && arready) begin
        r_data <= rd_word;
        r_resp <= rd_resp;
      end
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_out
    assign ctrl_regs[32*g +: 32] = regs[g];
  end

  assign ctrl_wr_pulse = pulse;
  assign bresp         = b_resp;
  assign rresp         = r_resp;
  assign rdata         = r_data;

endmodule

// File: tb/tb_axi4lite_csr_slave.sv
// Directed bench for axi4lite_csr_slave.
// Linear sequence of steps with immediate assertions.
module tb_axi4lite_csr_slave;

  localparam int AW  = 16;
  localparam int NRW = 8;
  localparam int NRO = 8;

  logic clk = 1'b0;
  logic rst;
  logic awvalid, awready;
  logic [AW-1:0] awaddr;
  logic [2:0] awprot;
  logic wvalid, wready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic bvalid, bready;
  logic [1:0] bresp;
  logic arvalid, arready;
  logic [AW-1:0] araddr;
  logic [2:0] arprot;
  logic rvalid, rready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic [NRW*32-1:0] ctrl_regs;
  logic [NRW-1:0] ctrl_wr_pulse;
  logic [NRO*32-1:0] status_in;

  int tests = 0;
  int fails = 0;

  axi4lite_csr_slave #(
    .ADDR_WIDTH(AW), .NUM_RW(NRW), .NUM_RO(NRO),
    .RW_RESET_VAL(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready),
    .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rresp(rresp),
    .ctrl_regs(ctrl_regs),
    .ctrl_wr_pulse(ctrl_wr_pulse),
    .status_in(status_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] reg_of(int i);
    return ctrl_regs[32*i +: 32];
  endfunction

  task automatic do_write(input logic [AW-1:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s,
                          output logic [1:0] resp,
                          output logic [NRW-1:0] pls,
                          output logic ok);
    resp = 2'bxx;
    pls = 'x;
    ok = 1'b0;
    awvalid = 1'b1; awaddr = a;
    wvalid = 1'b1; wdata = d; wstrb = s;
    bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bvalid) begin
        ok = 1'b1; resp = bresp; pls = ctrl_wr_pulse;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic do_read(input logic [AW-1:0] a,
                         output logic [31:0] d,
                         output logic [1:0] resp,
                         output logic ok);
    d = 'x; resp = 2'bxx; ok = 1'b0;
    arvalid = 1'b1; araddr = a; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rvalid) begin
        ok = 1'b1; d = rdata; resp = rresp;
        break;
      end
      tick();
    end
    tick();
  endtask

  initial begin
    logic [1:0] r;
    logic [NRW-1:0] p;
    logic ok;
    logic [31:0] d;

    rst = 1'b1;
    awvalid = 0; awaddr = '0; awprot = '0;
    wvalid = 0; wdata = '0; wstrb = '0;
    bready = 0; arvalid = 0; araddr = '0;
    arprot = '0; rready = 0;
    status_in = '0;
    status_in[31:0] = 32'hCAFEF00D;

    // reset state
    tick(); tick();
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_pulse", ctrl_wr_pulse, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_reg0", reg_of(0), 0);
    rst = 1'b0;
    tick();
    chk("post_awready", awready, 1);
    chk("post_wready", wready, 1);
    chk("post_arready", arready, 1);

    // AW+W same cycle to 0x04
    awvalid = 1; awaddr = 16'h0004;
    wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    tick();
    awvalid = 0; wvalid = 0;
    chk("t1_bvalid_c1", bvalid, 0);
    tick();
    chk("t1_bvalid_c2", bvalid, 1);
    chk("t1_bresp", bresp, 2'b00);
    chk("t1_reg1", reg_of(1), 32'hDEADBEEF);
    chk("t1_pulse", ctrl_wr_pulse, 8'h02);
    tick();
    chk("t1_pulse_off", ctrl_wr_pulse, 8'h00);
    chk("t1_bvalid_hold", bvalid, 1);
    chk("t1_bresp_hold", bresp, 2'b00);
    chk("t1_awready_resp", awready, 0);
    bready = 1;
    tick();
    chk("t1_bvalid_done", bvalid, 0);
    chk("t1_awready_idle", awready, 1);

    // W three cycles before AW, partial strobe
    wvalid = 1; wdata = 32'h11223344; wstrb = 4'h5;
    tick();
    wvalid = 0;
    chk("t2_wready_haveW", wready, 0);
    chk("t2_awready_haveW", awready, 1);
    tick(); tick();
    awvalid = 1; awaddr = 16'h0000;
    tick();
    awvalid = 0;
    chk("t2_bvalid_early", bvalid, 0);
    tick();
    chk("t2_bvalid", bvalid, 1);
    chk("t2_bresp", bresp, 2'b00);
    chk("t2_reg0", reg_of(0), 32'h00220044);
    tick();
    chk("t2_bvalid_done", bvalid, 0);

    // RO write, decode error write/read
    do_write(16'h0020, 32'h12345678, 4'hF, r, p, ok);
    chk("t3_ro_ok", ok, 1);
    chk("t3_ro_bresp", r, 2'b10);
    chk("t3_ro_pulse", p, 8'h00);
    chk("t3_ro_reg0", reg_of(0), 32'h00220044);
    chk("t3_ro_reg1", reg_of(1), 32'hDEADBEEF);
    do_write(16'h0040, 32'h87654321, 4'hF, r, p, ok);
    chk("t3_dec_ok", ok, 1);
    chk("t3_dec_bresp", r, 2'b11);
    chk("t3_dec_pulse", p, 8'h00);
    do_read(16'h0040, d, r, ok);
    chk("t3_rdec_ok", ok, 1);
    chk("t3_rdec_rresp", r, 2'b11);
    chk("t3_rdec_rdata", d, 0);
    do_read(16'h0004, d, r, ok);
    chk("t3_rd_reg1", d, 32'hDEADBEEF);
    chk("t3_rd_reg1_resp", r, 2'b00);

    // status read held under backpressure
    rready = 0;
    arvalid = 1; araddr = 16'h0020;
    tick();
    arvalid = 0;
    status_in[31:0] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_rvalid", rvalid, 1);
      chk("t4_rdata", rdata, 32'hCAFEF00D);
      chk("t4_rresp", rresp, 2'b00);
      chk("t4_arready", arready, 0);
      tick();
    end
    rready = 1;
    tick();
    chk("t4_rvalid_done", rvalid, 0);
    chk("t4_arready_idle", arready, 1);
    status_in[31:0] = 32'hCAFEF00D;

    // read reg2 in the commit cycle of a write to it
    bready = 1; rready = 1;
    awvalid = 1; awaddr = 16'h0008;
    wvalid = 1; wdata = 32'h5; wstrb = 4'hF;
    tick();
    awvalid = 0; wvalid = 0;
    arvalid = 1; araddr = 16'h0008;
    tick();
    arvalid = 0;
    chk("t5_rvalid", rvalid, 1);
    chk("t5_rdata_old", rdata, 32'h0);
    chk("t5_bvalid", bvalid, 1);
    chk("t5_reg2", reg_of(2), 32'h5);
    tick();
    chk("t5_both_done", {bvalid, rvalid}, 2'b00);
    do_read(16'h0008, d, r, ok);
    chk("t5_rd_ok", ok, 1);
    chk("t5_rdata_new", d, 32'h5);

    // reset while holding AW only
    awvalid = 1; awaddr = 16'h000C;
    tick();
    awvalid = 0;
    chk("t6_haveaw_aw", awready, 0);
    chk("t6_haveaw_w", wready, 1);
    rst = 1;
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_bvalid", bvalid, 0);
      tick();
    end
    for (int i = 0; i < NRW; i++)
      chk("t6_reg_reset", reg_of(i), 32'h0);
    chk("t6_awready", awready, 1);
    wvalid = 1; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    tick();
    wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_lone_w", bvalid, 0);
      tick();
    end
    awvalid = 1; awaddr = 16'h0010;
    tick();
    awvalid = 0;
    tick();
    chk("t6_late_bvalid", bvalid, 1);
    chk("t6_late_bresp", bresp, 2'b00);
    chk("t6_reg4", reg_of(4), 32'hA5A5A5A5);
    chk("t6_reg3", reg_of(3), 32'h0);
    chk("t6_pulse4", ctrl_wr_pulse, 8'h10);
    tick();
    do_write(16'h000C, 32'hAABBCCDD, 4'hF, r, p, ok);
    chk("t6_new_ok", ok, 1);
    chk("t6_new_bresp", r, 2'b00);
    chk("t6_new_pulse", p, 8'h08);
    chk("t6_new_reg3", reg_of(3), 32'hAABBCCDD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4lite_csr_slave.md
AXI4LITE_CSR_SLAVE -- requirements
Module: axi4lite_csr_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: width of awaddr/araddr.
REQ-002 SHALL have parameter NUM_RW, default 8: number of 32-bit read/write control registers at word indices 0..NUM_RW-1.
REQ-003 SHALL have parameter NUM_RO, default 8: number of 32-bit read-only status registers at word indices NUM_RW..NUM_RW+NUM_RO-1.
REQ-004 SHALL have parameter RW_RESET_VAL, default 0 (32-bit): reset value of every RW register.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have ports awvalid (input, 1), awready (output, 1), awaddr (input, ADDR_WIDTH) and awprot (input, 3); awprot is ignored.
REQ-009 SHALL have ports wvalid (input, 1), wready (output, 1), wdata (input, 32) and wstrb (input, 4).
REQ-010 SHALL have ports bvalid (output, 1), bready (input, 1) and bresp (output, 2).
REQ-011 SHALL have ports arvalid (input, 1), arready (output, 1), araddr (input, ADDR_WIDTH) and arprot (input, 3); arprot is ignored.
REQ-012 SHALL have ports rvalid (output, 1), rready (input, 1), rdata (output, 32) and rresp (output, 2).
REQ-013 SHALL have port ctrl_regs, output, NUM_RW*32: RW register contents; register i occupies bits [32i+31:32i].
REQ-014 SHALL have port ctrl_wr_pulse, output, NUM_RW: bit i is high for one cycle after each accepted write to RW register i.
REQ-015 SHALL have port status_in, input, NUM_RO*32: live status words, packed in the same layout as ctrl_regs.

Function
REQ-016 SHALL decode the word index from addr[ADDR_WIDTH-1:2] and ignore addr[1:0].
REQ-017 SHALL drive the write FSM through states W_IDLE, W_HAVE_AW, W_HAVE_W and W_RESP.
REQ-018 SHALL hold awready=1 in W_IDLE and W_HAVE_W, hold wready=1 in W_IDLE and W_HAVE_AW, and deassert both in W_RESP.
REQ-019 SHALL latch awaddr on an AW handshake and wdata/wstrb on a W handshake; AW and W may arrive in either order or in the same cycle.
REQ-020 SHALL, once both AW and W are held, update the target register next cycle, merging bytes per wstrb, enter W_RESP and assert bvalid in that same cycle.
REQ-021 SHALL return bresp OKAY and pulse ctrl_wr_pulse for an RW hit; bresp SLVERR and no update for an RO hit; bresp DECERR and no update for an out-of-range index.
REQ-022 SHALL hold bvalid and bresp stable until bready, then return to W_IDLE; with bready already high, W_IDLE is reached the cycle after bvalid rises.
REQ-023 SHALL drive the read FSM through states R_IDLE and R_RESP, with arready=1 only in R_IDLE.
REQ-024 SHALL, on an AR handshake, register rdata/rresp from values at the handshake cycle and assert rvalid next cycle (1-cycle latency).
REQ-025 SHALL return OKAY with register or status_in data for an in-range read, and DECERR with rdata=0 for an out-of-range read.
REQ-026 SHALL hold rvalid, rdata and rresp stable until rready.
REQ-027 SHALL run the read and write paths independently; a read and a register update in the same cycle to the same register return the pre-write value.
REQ-028 SHALL encode responses as OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.

Reset
REQ-029 SHALL, while rst=1, force bvalid, rvalid, awready, wready, arready and ctrl_wr_pulse to 0, rdata to 0, bresp/rresp to OKAY, RW registers to RW_RESET_VAL and both FSMs to idle.
REQ-030 SHALL assert the ready outputs in the first cycle after rst deasserts.
REQ-031 SHALL abandon any in-flight transaction on reset mid-operation, with no response issued afterwards.

Structure
REQ-032 SHALL place the response encodings and the write/read FSM state enums in shared package axi4lite_csr_pkg.
REQ-033 SHALL be a single module with no sub-module, the register array inline; it SHALL be connectable to the slave modport of the team's AXI4-Lite interface.

Verification
REQ-034 SHALL verify: AW+W in the same cycle, addr 0x04, data 0xDEADBEEF, wstrb 0xF -> bvalid 2 cycles later, bresp 00, reg1=0xDEADBEEF, ctrl_wr_pulse[1] high for 1 cycle.
REQ-035 SHALL verify: W (data 0x11223344, wstrb 0x5) 3 cycles before AW to addr 0x00 (reg0=0) -> reg0=0x00220044, bresp 00.
REQ-036 SHALL verify: write to addr 0x20 (RO) -> bresp 10, status unchanged; write to 0x40 -> bresp 11; read of 0x40 -> rresp 11, rdata 0.
REQ-037 SHALL verify: status_in word0=0xCAFEF00D, read 0x20 with rready low for 5 cycles -> rvalid held, rdata 0xCAFEF00D stable, arready 0 until rready.
REQ-038 SHALL verify: read of 0x08 in the same cycle as reg2 updates from 0x0 to 0x5 -> rdata 0x0; a subsequent read returns 0x5.
REQ-039 SHALL verify: rst asserted while W_HAVE_AW -> no bvalid; after reset, RW registers equal RW_RESET_VAL and a new write completes normally.
